mdio_phy_responder: RTL and testbench
=====================================

# mdio_phy_responder

PHY-side MDIO management target (IEEE 802.3 Clause 22). It lets the FPGA act as the managed end of the MDC/MDIO bus: it decodes read and write frames from an external or on-chip station manager and serves a 32×16 register file. It sits beside the PHY configuration master in Ethernet bring-up designs, as a PHY emulator for loopback tests and as a bus target for simulation. All logic runs on sys_clk; MDC is treated as a data signal and oversampled.

## Interface
Parameters:
- PHY_ADDR, 5'd1: address this target answers to.
- PHY_ID1, 16'h001C: reset and read-only value of register 2.
- PHY_ID2, 16'hC916: reset and read-only value of register 3.
- CTRL_RST_VAL, 16'h1140: reset value of register 0.
- MDC_TMO, 16'd4096: number of sys_clk cycles without an MDC rising edge before the frame is aborted.

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock; at least 8× the MDC frequency.
- sys_rst  in  1  synchronous active-high reset.
- eth_mdc  in  1  management clock from the station manager (asynchronous).
- eth_mdio  inout  1  bidirectional management data. Driven only during the read turnaround and read data bits; otherwise high-Z.
- phy_status  in  16  live value returned for register 1 (read-only).
- wr_evt  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  5  register address of the last committed write.
- wr_data  out  16  data of the last committed write.
- rd_evt  out  1  one-cycle pulse when read data has been latched for shifting out.
- frame_err  out  1  one-cycle pulse when a frame is aborted (bad ST, bad OP, write TA ≠ 10, or timeout).

## Operation
- eth_mdc and eth_mdio pass through 2-flop synchronisers. An MDC rising edge is detected when the synchronised MDC is 1 and its previous value was 0; that cycle is the bit strobe. All state advances only on strobes.
- FSM states:
  - **PRE**: counts consecutive sampled 1s, saturating at 32. A 0 after at least 32 ones is treated as ST bit 0 and moves to ST. A 0 after fewer than 32 ones resets the count.
  - **ST**: expects 1. On 0, pulse frame_err and return to PRE.
  - **OP**: 2 bits. 10 = read, 01 = write. 00 or 11 pulse frame_err and return to PRE.
  - **PHYAD**: 5 bits, MSB first. Sets the match flag if equal to PHY_ADDR.
  - **REGAD**: 5 bits, MSB first. For a matched read, the register is latched into the shift register on the strobe of the last REGAD bit, and rd_evt pulses.
  - **TA**:
    - Read: the first TA strobe leaves eth_mdio at Z. On the second TA strobe the block starts driving 0.
    - Write: expects 1 then 0. Any other value pulses frame_err and returns to PRE, with no commit.
  - **DATA**: 16 bits, MSB first.
    - Write: shifts the sampled bits in. On the 16th strobe, a matched write commits.
    - Read: on each strobe, drives the next bit (D15 first). The strobe that follows D0 being driven releases eth_mdio to Z and returns to PRE.
- An unmatched PHYAD tracks the frame to its end but never drives the bus and never commits.
- Register map:
  - Reg 0: read/write. Bit 15 is self-clearing: writing 1 reloads every register to its reset value on the commit cycle, and bit 15 always reads 0.
  - Reg 1: returns phy_status. Writes are ignored.
  - Regs 2 and 3: return PHY_ID1 and PHY_ID2. Writes are ignored.
  - Regs 4–31: read/write, reset 0.
  - wr_evt pulses only for writes to read/write registers, and wr_addr/wr_data update in that same cycle.
- If a frame is in progress (any state other than PRE, or a non-zero preamble count) and MDC_TMO cycles pass without a strobe: pulse frame_err, release the bus, return to PRE with count 0.

## Timing
- Reset values: eth_mdio Z, wr_evt 0, wr_addr 0, wr_data 0, rd_evt 0, frame_err 0, FSM in PRE with count 0, register file at defaults.
- Output change occurs 3–4 sys_clk cycles after the eth_mdc rising edge (2 synchroniser stages, edge detect, output register). The station manager samples on the next MDC rise.
- MDC high time and low time must each be at least 4 sys_clk cycles.
- wr_evt and frame_err assert in the cycle after the relevant strobe.
- sys_rst asserted mid-read releases eth_mdio in the cycle after reset is sampled.
- A write commit to reg 0 bit 15 together with a read latch is impossible, since one frame is in flight at a time.

## Configuration
- MDIO_RESP_PREAMBLE_SUPPRESS_EN:
  - When defined, PRE accepts ST after a single sampled 1 (preamble suppression, as advertised by BMSR bit 6). The block also forces bit 6 of the returned register-1 value to 1.
  - When undefined, a full 32-bit preamble is mandatory and register 1 is returned unmodified.

## Structure
- Package mdio_pkg: FSM state enum; opcode constants OP_RD = 2'b10 and OP_WR = 2'b01; ST pattern; register address constants REG_BMCR = 0, REG_BMSR = 1, REG_ID1 = 2, REG_ID2 = 3; preamble length 32.
- One sub-module, mdio_sync_edge: 2-flop synchroniser for MDC and MDIO plus the MDC rising-edge strobe.

## Test plan
- **Write then read back**: 32 ones, then write frame to PHYAD 1, REG 4, data 16'hA5C3, then a read of REG 4.
  - Required response: wr_evt pulses once with wr_addr = 4 and wr_data = 16'hA5C3.
  - The read returns TA = Z,0 then 16'hA5C3 on eth_mdio.
- **PHY ID reads**: read REG 2, then REG 3.
  - Required response: 16'h001C and 16'hC916.
  - A write of 16'hFFFF to REG 2 produces no wr_evt and the next read still returns 16'h001C.
- **Address mismatch**: write to PHYAD 5.
  - Required response: no wr_evt, eth_mdio stays Z for the whole frame.
  - A following read of PHYAD 1 still succeeds.
- **Soft reset**: write 16'h8000 to REG 0, then read REG 0 and REG 4.
  - Required response: REG 0 reads 16'h1140 and REG 4 reads 16'h0000.
- **Error paths**: OP = 11, then a write with TA = 11.
  - Required response: frame_err pulses for each frame and nothing is committed.
- **Abort and recovery**: MDC stopped for 5000 sys_clk cycles mid-read (after D8), then sys_rst asserted for one cycle mid-frame.
  - Required response: frame_err pulses and eth_mdio is released to Z.
  - The next full frame completes correctly.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg: Clause 22 MDIO frame constants and responder FSM states
package mdio_pkg;
  typedef enum logic [2:0] {S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] ST_PAT = 2'b01;
  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1 = 5'd2;
  localparam logic [4:0] REG_ID2 = 5'd3;
  localparam logic [5:0] PRE_LEN = 6'd32;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-flop synchronisers for MDC/MDIO and MDC rising-edge bit strobe
module mdio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic mdio_s,
  output logic strb
);
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q <= {mdc_q[1:0], mdc};
      mdio_q <= {mdio_q[0], mdio};
    end
  end
  assign mdio_s = mdio_q[1];
  assign strb = mdc_q[1] & ~mdc_q[2];
endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO PHY target with 32x16 register file (MDIO_RESP_PREAMBLE_SUPPRESS_EN enables preamble suppression)
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h001C,
  parameter logic [15:0] PHY_ID2      = 16'hC916,
  parameter logic [15:0] CTRL_RST_VAL = 16'h1140,
  parameter logic [15:0] MDC_TMO      = 16'd4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        eth_mdc,
  inout  wire         eth_mdio,
  input  logic [15:0] phy_status,
  output logic        wr_evt,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_evt,
  output logic        frame_err
);
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_MIN = 6'd1;
  localparam logic [15:0] BMSR_OR = 16'h0040;
`else
  localparam logic [5:0] PRE_MIN = PRE_LEN;
  localparam logic [15:0] BMSR_OR = 16'h0000;
`endif
  localparam logic [31:0][15:0] REG_RST = {496'd0, CTRL_RST_VAL};
  logic mdio_s, strb;
  state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic [15:0] sh, sh_n, sh_in, rd_val, tmo, tmo_n;
  logic [4:0] regad, regad_n, ra;
  logic op_rd, op_rd_n, match, match_n, oe, oe_n, dout, dout_n;
  logic commit, rd_n, err, busy, wr_ok;
  logic [31:0][15:0] regs;
  mdio_sync_edge u_sync (
    .clk(sys_clk),
    .rst(sys_rst),
    .mdc(eth_mdc),
    .mdio(eth_mdio),
    .mdio_s(mdio_s),
    .strb(strb)
  );
  assign eth_mdio = oe ? dout : 1'bz;
  assign sh_in = {sh[14:0], mdio_s};
  assign ra = sh_in[4:0];
  assign rd_val = ra == REG_BMSR ? (phy_status | BMSR_OR) :
                  ra == REG_ID1  ? PHY_ID1 :
                  ra == REG_ID2  ? PHY_ID2 :
                  ra == REG_BMCR ? (regs[0] & 16'h7FFF) : regs[ra];
  assign wr_ok = commit && (regad == REG_BMCR || regad > REG_ID2);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    op_rd_n = op_rd;
    match_n = match;
    regad_n = regad;
    oe_n = oe;
    dout_n = dout;
    commit = 1'b0;
    rd_n = 1'b0;
    err = 1'b0;
    busy = state != S_PRE || cnt != 6'd0;
    tmo_n = strb || !busy ? 16'd0 : tmo + 16'd1;
    if (strb) begin
      cnt_n = cnt + 6'd1;
      sh_n = sh_in;
      case (state)
        S_PRE: begin
          cnt_n = mdio_s != ST_PAT[1] ? (cnt == PRE_LEN ? cnt : cnt + 6'd1) : 6'd0;
          state_n = mdio_s == ST_PAT[1] && cnt >= PRE_MIN ? S_ST : S_PRE;
        end
        S_ST: begin
          cnt_n = 6'd0;
          state_n = S_OP;
          err = mdio_s != ST_PAT[0];
        end
        S_OP: if (cnt[0]) begin
          cnt_n = 6'd0;
          op_rd_n = sh_in[1:0] == OP_RD;
          state_n = S_PHYAD;
          err = sh_in[1:0] != OP_RD && sh_in[1:0] != OP_WR;
        end
        S_PHYAD: if (cnt == 6'd4) begin
          cnt_n = 6'd0;
          match_n = sh_in[4:0] == PHY_ADDR;
          state_n = S_REGAD;
        end
        S_REGAD: if (cnt == 6'd4) begin
          cnt_n = 6'd0;
          regad_n = ra;
          state_n = S_TA;
          rd_n = op_rd && match;
          sh_n = rd_n ? rd_val : sh_in;
        end
        S_TA: begin
          sh_n = sh;
          if (!cnt[0]) err = !op_rd && !mdio_s;
          else begin
            cnt_n = 6'd0;
            state_n = S_DATA;
            err = !op_rd && mdio_s;
            oe_n = op_rd && match;
            dout_n = 1'b0;
          end
        end
        S_DATA: if (op_rd) begin
          if (cnt == 6'd16) begin
            oe_n = 1'b0;
            state_n = S_PRE;
            cnt_n = 6'd0;
          end else begin
            dout_n = sh[15];
            sh_n = {sh[14:0], 1'b0};
          end
        end else if (cnt == 6'd15) begin
          commit = match;
          state_n = S_PRE;
          cnt_n = 6'd0;
        end
        default: state_n = S_PRE;
      endcase
    end else err = busy && tmo == MDC_TMO - 16'd1;
    if (err) begin
      state_n = S_PRE;
      cnt_n = 6'd0;
      oe_n = 1'b0;
      tmo_n = 16'd0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_PRE;
      cnt <= '0;
      sh <= '0;
      op_rd <= 1'b0;
      match <= 1'b0;
      regad <= '0;
      oe <= 1'b0;
      dout <= 1'b0;
      tmo <= '0;
      wr_evt <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_evt <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      op_rd <= op_rd_n;
      match <= match_n;
      regad <= regad_n;
      oe <= oe_n;
      dout <= dout_n;
      tmo <= tmo_n;
      wr_evt <= wr_ok;
      rd_evt <= rd_n;
      frame_err <= err;
      if (wr_ok) begin
        wr_addr <= regad;
        wr_data <= sh_n;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst || (wr_ok && regad == REG_BMCR && sh_n[15])) regs <= REG_RST;
    else if (wr_ok) regs[regad] <= regad == REG_BMCR ? (sh_n & 16'h7FFF) : sh_n;
  end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: station-manager bench with a register-map reference model
module tb_mdio_phy_responder;
`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic [15:0] BMSR_OR = 16'h0040;
`else
  localparam logic [15:0] BMSR_OR = 16'h0000;
`endif
  logic sys_clk = 1'b0, sys_rst = 1'b1, eth_mdc = 1'b0, tb_oe = 1'b0, tb_bit = 1'b1;
  logic [15:0] phy_status = 16'h7809;
  logic wr_evt, rd_evt, frame_err;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  wire mdio;
  int vectors = 0, miscompares = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [15:0] m_regs [32];
  assign mdio = tb_oe ? tb_bit : 1'bz;
  pullup (mdio);
  always #5 sys_clk = ~sys_clk;
  mdio_phy_responder dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .eth_mdc(eth_mdc),
    .eth_mdio(mdio),
    .phy_status(phy_status),
    .wr_evt(wr_evt),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_evt(rd_evt),
    .frame_err(frame_err)
  );
  always @(negedge sys_clk) begin
    if (wr_evt) wr_cnt++;
    if (rd_evt) rd_cnt++;
    if (frame_err) err_cnt++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end, required finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0000;
    m_regs[0] = 16'h1140;
  endtask
  task automatic m_write(input logic [4:0] a, input logic [15:0] d, output logic rw);
    rw = a == 5'd0 || a > 5'd3;
    if (a == 5'd0 && d[15]) m_reset();
    else if (rw) m_regs[a] = a == 5'd0 ? {1'b0, d[14:0]} : d;
  endtask
  function automatic logic [15:0] m_read(input logic [4:0] a);
    return a == 5'd1 ? (phy_status | BMSR_OR) : a == 5'd2 ? 16'h001C : a == 5'd3 ? 16'hC916 : m_regs[a];
  endfunction
  task automatic clk_bit(input logic b, input logic drv, output logic s);
    tb_bit = b;
    tb_oe = drv;
    repeat (5) @(negedge sys_clk);
    s = mdio;
    eth_mdc = 1'b1;
    repeat (5) @(negedge sys_clk);
    eth_mdc = 1'b0;
  endtask
  task automatic send_bits(input logic [15:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) clk_bit(v[i], 1'b1, s);
  endtask
  task automatic send_hdr(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
    logic s;
    for (int i = 0; i < 32; i++) clk_bit(1'b1, 1'b1, s);
    send_bits(16'b01, 2);
    send_bits({14'd0, op}, 2);
    send_bits({11'd0, phy}, 5);
    send_bits({11'd0, ra}, 5);
  endtask
  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    send_hdr(2'b01, phy, ra);
    send_bits(16'b10, 2);
    send_bits(d, 16);
    tb_oe = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask
  task automatic wr_chk(input string tag, input logic [4:0] ra, input logic [15:0] d);
    int w0;
    logic rw;
    w0 = wr_cnt;
    do_write(5'd1, ra, d);
    m_write(ra, d, rw);
    chk({tag, "_wr_evt"}, wr_cnt - w0, {31'd0, rw});
    if (rw) begin
      chk({tag, "_wr_addr"}, wr_addr, ra);
      chk({tag, "_wr_data"}, wr_data, d);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] exp, input logic hit);
    logic s [20];
    logic [15:0] d;
    int r0;
    r0 = rd_cnt;
    send_hdr(2'b10, phy, ra);
    for (int k = 0; k < 19; k++) clk_bit(1'b1, 1'b0, s[k]);
    repeat (5) @(negedge sys_clk);
    s[19] = mdio;
    for (int i = 0; i < 16; i++) d[15-i] = s[3+i];
    chk({tag, "_ta_z"}, s[1], 1);
    chk({tag, "_ta_0"}, s[2], hit ? 0 : 1);
    chk({tag, "_data"}, d, hit ? exp : 16'hFFFF);
    chk({tag, "_release"}, s[19], 1);
    chk({tag, "_rd_evt"}, rd_cnt - r0, {31'd0, hit});
  endtask
  initial begin
    logic [4:0] a, b;
    logic [15:0] d;
    logic s;
    int w0, e0;
    m_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_wr_evt", wr_evt, 0);
    chk("rst_rd_evt", rd_evt, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_mdio", mdio, 1);
    wr_chk("w4", 5'd4, 16'hA5C3);
    rd_chk("r4", 5'd1, 5'd4, 16'hA5C3, 1'b1);
    rd_chk("id1", 5'd1, 5'd2, 16'h001C, 1'b1);
    rd_chk("id2", 5'd1, 5'd3, 16'hC916, 1'b1);
    wr_chk("w_id1", 5'd2, 16'hFFFF);
    rd_chk("id1_again", 5'd1, 5'd2, 16'h001C, 1'b1);
    w0 = wr_cnt;
    do_write(5'd5, 5'd4, 16'h1234);
    chk("mis_wr_evt", wr_cnt - w0, 0);
    rd_chk("mis_rd", 5'd5, 5'd4, 16'h0000, 1'b0);
    rd_chk("after_mis", 5'd1, 5'd4, 16'hA5C3, 1'b1);
    for (int it = 0; it < 6; it++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      phy_status = 16'($urandom);
      wr_chk("rnd", a, d);
      rd_chk("rnd_same", 5'd1, a, m_read(a), 1'b1);
      rd_chk("rnd_other", 5'd1, b, m_read(b), 1'b1);
    end
    wr_chk("w4b", 5'd4, 16'h0F0F);
    wr_chk("soft", 5'd0, 16'h8000);
    rd_chk("soft_bmcr", 5'd1, 5'd0, 16'h1140, 1'b1);
    rd_chk("soft_r4", 5'd1, 5'd4, 16'h0000, 1'b1);
    wr_chk("w5", 5'd5, 16'h5A5A);
    e0 = err_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 32; i++) clk_bit(1'b1, 1'b1, s);
    send_bits(16'b0111, 4);
    tb_oe = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("op11_err", err_cnt - e0, 1);
    send_hdr(2'b01, 5'd1, 5'd5);
    send_bits(16'b11, 2);
    tb_oe = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("ta11_err", err_cnt - e0, 2);
    chk("err_no_commit", wr_cnt - w0, 0);
    rd_chk("err_r5", 5'd1, 5'd5, 16'h5A5A, 1'b1);
    e0 = err_cnt;
    send_hdr(2'b10, 5'd1, 5'd2);
    for (int k = 0; k < 10; k++) clk_bit(1'b1, 1'b0, s);
    repeat (5) @(negedge sys_clk);
    chk("abort_d8", mdio, 0);
    repeat (5000) @(negedge sys_clk);
    chk("abort_err", err_cnt - e0, 1);
    chk("abort_release", mdio, 1);
    rd_chk("abort_next", 5'd1, 5'd3, 16'hC916, 1'b1);
    send_hdr(2'b10, 5'd1, 5'd2);
    for (int k = 0; k < 5; k++) clk_bit(1'b1, 1'b0, s);
    repeat (5) @(negedge sys_clk);
    chk("rst_mid_drive", mdio, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_mid_release", mdio, 1);
    chk("rst_mid_wr_addr", wr_addr, 0);
    m_reset();
    rd_chk("rst_r5", 5'd1, 5'd5, 16'h0000, 1'b1);
    d = 16'($urandom);
    wr_chk("post_rst", 5'd7, d);
    rd_chk("post_rst_r7", 5'd1, 5'd7, d, 1'b1);
    rd_chk("post_rst_bmcr", 5'd1, 5'd0, 16'h1140, 1'b1);
    chk("total_frame_err", err_cnt, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
